// File: rtl/twiddle_fetch_pkg.sv
// Shared definitions for the twiddle fetch initiator: quadrant mapping,
// full-range twiddle address function and parameter legality check.
package twiddle_fetch_pkg;

  // Multiplier applied to the in-quadrant offset, indexed by {c[M-1], c[M-2]}.
  // Quadrants 0..3 map to multipliers 0, 2, 1, 3.
  localparam logic [3:0][1:0] QUAD_MULT = {2'd3, 2'd1, 2'd2, 2'd0};

  // True when the parameter set is usable by the reduction logic.
  function automatic bit params_ok(int unsigned nn, int unsigned log_m,
                                   int unsigned tab_lat);
    return (nn >= 32'd4) && (log_m >= 32'd2) && (log_m <= nn) &&
           (tab_lat >= 32'd1);
  endfunction

  // Full-range twiddle address for sample index c within a span of 2^log_m.
  function automatic int unsigned tw_addr(int unsigned c, int unsigned nn,
                                          int unsigned log_m);
    int unsigned q;
    int unsigned low;
    int unsigned num;
    int unsigned mask;
    q    = (c >> (log_m - 32'd2)) & 32'd3;
    low  = c & ((32'd1 << (log_m - 32'd2)) - 32'd1);
    num  = low << (nn - log_m);
    mask = (32'd1 << nn) - 32'd1;
    return (num * 32'(QUAD_MULT[q[1:0]])) & mask;
  endfunction

endpackage

// File: rtl/twiddle_fetch_tw_delay.sv
// Width x depth shift register with synchronous reset; shifts every cycle.
module twiddle_fetch_tw_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift chain: stage 0 takes d, every later stage takes its predecessor.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign q = r_sr[DEPTH-1];

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle fetch initiator: counts samples in a stage span, issues the
// full-range twiddle address, aligns it to table latency and captures the
// reconstructed twiddle for the stage multiplier.
module twiddle_fetch
  import twiddle_fetch_pkg::*;
#(
  parameter int unsigned NN      = 6,
  parameter int unsigned LOG_M   = 6,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TAB_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic             sync,
  output logic [NN-1:0]    taddr,
  output logic [NN-1:0]    taddr_sel,
  input  logic [WIDTH-1:0] tab_data_r,
  input  logic [WIDTH-1:0] tab_data_i,
  output logic             tw_en,
  output logic [WIDTH-1:0] tw_r,
  output logic [WIDTH-1:0] tw_i,
  output logic             tw_bypass
);

  if (!params_ok(NN, LOG_M, TAB_LAT)) begin : g_bad_params
    $error("twiddle_fetch: illegal NN/LOG_M/TAB_LAT combination");
  end

  logic [LOG_M-1:0] r_count;
  logic [LOG_M-1:0] w_c;
  logic [NN-1:0]    w_addr;
  logic             w_cap_valid;

  // sync forces the current sample to index 0 of the frame.
  assign w_c    = sync ? '0 : r_count;
  assign w_addr = NN'(tw_addr(32'(w_c), NN, LOG_M));

  // Sample counter and address register; both advance only on accepted samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      taddr   <= '0;
    end else if (di_en) begin
      r_count <= w_c + LOG_M'(1);
      taddr   <= w_addr;
    end else if (sync) begin
      r_count <= '0;
    end
  end

  // Address-for-select, aligned with the table read data.
  twiddle_fetch_tw_delay #(
    .WIDTH (NN),
    .DEPTH (TAB_LAT)
  ) u_sel_dly (
    .clock (clock),
    .reset (reset),
    .d     (taddr),
    .q     (taddr_sel)
  );

  // Sample valid, arriving at the capture stage together with the table data.
  twiddle_fetch_tw_delay #(
    .WIDTH (1),
    .DEPTH (TAB_LAT + 1)
  ) u_vld_dly (
    .clock (clock),
    .reset (reset),
    .d     (di_en),
    .q     (w_cap_valid)
  );

  // Capture stage: twiddle and bypass hold between valid samples; tw_en strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      tw_en     <= 1'b0;
      tw_r      <= '0;
      tw_i      <= '0;
      tw_bypass <= 1'b0;
    end else begin
      tw_en <= w_cap_valid;
      if (w_cap_valid) begin
        tw_r      <= tab_data_r;
        tw_i      <= tab_data_i;
        tw_bypass <= (taddr_sel == '0);
      end
    end
  end

endmodule
